// File: rtl/sha3_perm_arbiter.sv
// ---------------------------------------------------------------------------
// sha3_perm_arbiter
//   Controller and arbiter for one shared Keccak-f[1600] round datapath
//   (one round per cycle). Grants the permutation to one of NREQ requesters,
//   sequences load -> ROUNDS rounds -> done for every absorbed block, and
//   keeps the grant locked to the owner until its last block has finished.
//   The 1600-bit state lives in the datapath; this block only drives the
//   select and strobe signals.
//
// Configuration macro:
//   SHA3_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                        no round-robin pointer.
//                           undefined -> round-robin from the rr pointer.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [NREQ] per-requester request (block valid while high)
//   last       in   [NREQ] block is the final block of its message
//   gnt        out  [NREQ] one-hot grant, also the block-input mux select
//   load       out  one-cycle strobe: state = (first ? 0 : state) ^ block
//   first      out  qualifies load: block starts a new message
//   round_en   out  datapath applies one round this cycle
//   round_idx  out  [RIW] round index applied this cycle (iota select)
//   blk_done   out  [NREQ] one-cycle pulse to the owner: permutation done
//   busy       out  high in every state except IDLE
// ---------------------------------------------------------------------------
module sha3_perm_arbiter #(
  parameter int NREQ   = 2,
  parameter int ROUNDS = 24,
  parameter int RIW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic            load,
  output logic            first,
  output logic            round_en,
  output logic [RIW-1:0]  round_idx,
  output logic [NREQ-1:0] blk_done,
  output logic            busy
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [OW-1:0]   owner_r, owner_s;
  logic            last_q_r, last_q_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] blk_done_r, blk_done_s;
  logic            load_r, load_s;
  logic            first_r, first_s;
  logic            round_en_r, round_en_s;
  logic            busy_r, busy_s;
  logic [RIW-1:0]  round_idx_r, round_idx_s;
  logic [OW-1:0]   win_s;
  logic            any_req_s;
`ifndef SHA3_ARB_FIXED_PRIO_EN
  logic [OW-1:0]   rr_r, rr_s;
`endif

  function automatic logic [NREQ-1:0] to_onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign gnt       = gnt_r;
  assign load      = load_r;
  assign first     = first_r;
  assign round_en  = round_en_r;
  assign round_idx = round_idx_r;
  assign blk_done  = blk_done_r;
  assign busy      = busy_r;

`ifdef SHA3_ARB_FIXED_PRIO_EN
  // Winner selection: lowest requesting index.
  always_comb begin
    win_s     = '0;
    any_req_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !any_req_s) begin
        win_s     = OW'(i);
        any_req_s = 1'b1;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end
`else
  // Winner selection: first requesting index at or above rr_r, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_s     = '0;
    any_req_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_r) + k) % NREQ;
      if (req[idx] && !any_req_s) begin
        win_s     = OW'(idx);
        any_req_s = 1'b1;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end
`endif

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_q_s    = last_q_r;
    gnt_s       = gnt_r;
    load_s      = 1'b0;
    first_s     = 1'b0;
    round_en_s  = 1'b0;
    round_idx_s = '0;
    blk_done_s  = '0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
    rr_s        = rr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_LOAD;
          owner_s = win_s;
          gnt_s   = to_onehot(win_s);
          load_s  = 1'b1;
          first_s = 1'b1;
        end else begin
          gnt_s   = '0;
        end
      end
      ST_LOAD: begin
        // The final-block flag is only meaningful while the block is loaded.
        last_q_s    = last[owner_r];
        state_s     = ST_RUN;
        round_en_s  = 1'b1;
        round_idx_s = '0;
      end
      ST_RUN: begin
        if (round_idx_r == RIW'(ROUNDS - 1)) begin
          state_s    = ST_DONE;
          blk_done_s = to_onehot(owner_r);
        end else begin
          round_en_s  = 1'b1;
          round_idx_s = round_idx_r + RIW'(1);
        end
      end
      ST_DONE: begin
        if (last_q_r) begin
          state_s = ST_IDLE;
          gnt_s   = '0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
          // Pointer advances only when a whole message has completed.
          rr_s    = (owner_r == OW'(NREQ - 1)) ? '0 : owner_r + OW'(1);
`endif
        end else if (req[owner_r]) begin
          state_s = ST_LOAD;
          load_s  = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Message lock: other requesters cannot break in mid-message.
        if (req[owner_r]) begin
          state_s = ST_LOAD;
          load_s  = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      last_q_r    <= 1'b0;
      gnt_r       <= '0;
      load_r      <= 1'b0;
      first_r     <= 1'b0;
      round_en_r  <= 1'b0;
      round_idx_r <= '0;
      blk_done_r  <= '0;
      busy_r      <= 1'b0;
`ifndef SHA3_ARB_FIXED_PRIO_EN
      rr_r        <= '0;
`endif
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      last_q_r    <= last_q_s;
      gnt_r       <= gnt_s;
      load_r      <= load_s;
      first_r     <= first_s;
      round_en_r  <= round_en_s;
      round_idx_r <= round_idx_s;
      blk_done_r  <= blk_done_s;
      busy_r      <= busy_s;
`ifndef SHA3_ARB_FIXED_PRIO_EN
      rr_r        <= rr_s;
`endif
    end
  end

endmodule

// File: tb/tb_sha3_perm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sha3_perm_arbiter
//   Scoreboard bench for sha3_perm_arbiter (NREQ=2). Directed stimulus pushes
//   the expected load / blk_done events (grant, first flag, cycle) into a
//   queue; a negedge monitor pops and compares each event as the DUT shows
//   it, and also checks round sequencing and the output invariants.
// ---------------------------------------------------------------------------
module tb_sha3_perm_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] last;
  logic [1:0] gnt;
  logic       load;
  logic       first;
  logic       round_en;
  logic [4:0] round_idx;
  logic [1:0] blk_done;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_done;
    logic [1:0] vec;
    bit         first;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  // monitor-only state
  int         load_cyc = 0;
  int         rounds = 0;
  logic [1:0] cur_gnt = 2'b00;

  sha3_perm_arbiter #(.NREQ(2), .ROUNDS(24), .RIW(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .gnt(gnt), .load(load), .first(first), .round_en(round_en),
    .round_idx(round_idx), .blk_done(blk_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input bit d, input logic [1:0] v, input bit f, input int c);
    ev_t e;
    e.is_done = d;
    e.vec     = v;
    e.first   = f;
    e.cyc     = c;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_gnt"}, gnt, 0);
    check_eq({tag, "_load"}, load, 0);
    check_eq({tag, "_first"}, first, 0);
    check_eq({tag, "_round_en"}, round_en, 0);
    check_eq({tag, "_round_idx"}, round_idx, 0);
    check_eq({tag, "_blk_done"}, blk_done, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: pop and compare events, track rounds, check invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("gnt_onehot0", int'($onehot0(gnt)), 1);
      check_eq("strobe_exclusive", int'($countones({load, round_en, blk_done}) <= 1), 1);
      if (load) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_load", 1, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check_eq("load_kind", 0, int'(e.is_done));
          check_eq("load_gnt", gnt, e.vec);
          check_eq("load_first", first, int'(e.first));
          check_eq("load_cycle", cyc, e.cyc);
        end
        load_cyc = cyc;
        rounds   = 0;
        cur_gnt  = gnt;
      end
      if (round_en) begin
        check_eq("round_idx", round_idx, cyc - load_cyc - 1);
        check_eq("round_gnt", gnt, cur_gnt);
        rounds++;
      end
      if (blk_done != 2'b00) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check_eq("done_kind", 1, int'(e.is_done));
          check_eq("done_vec", blk_done, e.vec);
          check_eq("done_cycle", cyc, e.cyc);
          check_eq("round_count", rounds, 24);
        end
      end
    end
  end

  initial begin
    int t;
    int own[4];
    rst_n = 1'b0;
    req   = 2'b00;
    last  = 2'b00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single block, single message on requester 0.
    t = cyc;
    req = 2'b01; last = 2'b01;
    push(1'b0, 2'b01, 1'b1, t + 1);
    push(1'b1, 2'b01, 1'b0, t + 26);
    goto(t + 1);  req = 2'b00;
    goto(t + 27);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_gnt_after", gnt, 0);
    goto(t + 28);

    // Both requesting continuously out of reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SHA3_ARB_FIXED_PRIO_EN
    own = '{0, 0, 0, 1};
`else
    own = '{0, 1, 0, 1};
`endif
    t = cyc;
    req = 2'b11; last = 2'b11;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 2'b01 << own[k], 1'b1, t + 1 + 27 * k);
      push(1'b1, 2'b01 << own[k], 1'b0, t + 26 + 27 * k);
    end
`ifdef SHA3_ARB_FIXED_PRIO_EN
    goto(t + 55); req = 2'b10;
`endif
    goto(t + 82); req = 2'b00;
    goto(t + 108);

    // Three-block message on requester 1 while requester 0 waits.
    t = cyc;
    req = 2'b10; last = 2'b01;
    push(1'b0, 2'b10, 1'b1, t + 1);
    push(1'b1, 2'b10, 1'b0, t + 26);
    push(1'b0, 2'b10, 1'b0, t + 27);
    push(1'b1, 2'b10, 1'b0, t + 52);
    push(1'b0, 2'b10, 1'b0, t + 53);
    push(1'b1, 2'b10, 1'b0, t + 78);
    push(1'b0, 2'b01, 1'b1, t + 80);
    push(1'b1, 2'b01, 1'b0, t + 105);
    goto(t + 1);  req = 2'b11;
    goto(t + 30); last = 2'b11;   // latched only at the third load
    goto(t + 53); req = 2'b01;
    goto(t + 78);
    check_eq("t3_gnt_third_done", gnt, 2'b10);
    goto(t + 79);
    check_eq("t3_gnt_bubble", gnt, 2'b00);
    goto(t + 80); req = 2'b00;
    goto(t + 106);

    // Owner pauses after a non-last block: HOLD keeps the lock.
    t = cyc;
    req = 2'b10; last = 2'b01;
    push(1'b0, 2'b10, 1'b1, t + 1);
    push(1'b1, 2'b10, 1'b0, t + 26);
    push(1'b0, 2'b10, 1'b0, t + 32);
    push(1'b1, 2'b10, 1'b0, t + 57);
    push(1'b0, 2'b01, 1'b1, t + 59);
    push(1'b1, 2'b01, 1'b0, t + 84);
    goto(t + 1);  req = 2'b01;
    goto(t + 5);  last = 2'b11;
    for (int c = 27; c <= 31; c++) begin
      goto(t + c);
      check_eq("hold_gnt", gnt, 2'b10);
      check_eq("hold_load", load, 0);
      check_eq("hold_busy", busy, 1);
    end
    req = 2'b11;
    goto(t + 32); req = 2'b01;
    goto(t + 59); req = 2'b00;
    goto(t + 86);

    // Reset in the middle of a permutation.
    t = cyc;
    req = 2'b01; last = 2'b01;
    push(1'b0, 2'b01, 1'b1, t + 1);
    goto(t + 1);  req = 2'b00;
    goto(t + 12);
    check_eq("pre_reset_round_idx", round_idx, 10);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(t + 32);
    t = cyc;
    req = 2'b01;
    push(1'b0, 2'b01, 1'b1, t + 1);
    push(1'b1, 2'b01, 1'b0, t + 26);
    goto(t + 1);  req = 2'b00;
    goto(t + 28);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
